// File: rtl/knn_pkg.sv
// Shared constants and state encoding for the KNN byte streamer.
package knn_pkg;

    localparam logic [31:0] KNN_WORD_STRIDE  = 32'd4;
    localparam int          KNN_RECORD_BYTES = 3073;
    localparam logic [31:0] KNN_IMG_BASE     = 32'h0001_0000;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } knn_state_t;

endpackage

// File: rtl/knn_byte_fifo.sv
// Byte FIFO between the memory response path and the output stream.
// Registered pointers, combinational head; flush empties it in one cycle.
module knn_byte_fifo #(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        pop,
    input  logic        flush,
    output logic [7:0]  head,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // The issuer's credit accounting must keep pushes away from a full FIFO.
    assert property (@(posedge clk) disable iff (!resetn) !(push && full));

endmodule

// File: rtl/knn_byte_streamer.sv
// Read-burst engine: one word read per cycle, byte[7:0] of each word streamed out.
// Command to first byte 3 cycles; issue stalls on FIFO credit, so out_ready=0 never loses data.
module knn_byte_streamer
    import knn_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 12
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             mem_valid,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    knn_state_t       state;
    logic [31:0]      issue_addr;
    logic [LEN_W-1:0] issue_left;
    logic [LEN_W-1:0] out_left;
    logic             inflight;
    logic             drop;

    logic [CW-1:0]    fifo_count;
    logic             fifo_full_unused;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             push;
    logic             pop;
    logic             credit;
    logic             kill;
    logic             unused_rdata;

    assign unused_rdata = ^mem_rdata[31:8];

    assign kill      = abort && (state != IDLE);
    assign push      = mem_ready && inflight && !drop;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = fifo_empty ? 8'h00 : fifo_head;
    assign out_last  = (out_left == LEN_W'(1)) && out_valid;

    // A byte popped this cycle frees a slot in time for a request issued now.
    assign credit = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight})
                  < ((CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop});

    assign mem_valid = (state == STREAM) && (issue_left != '0) && credit;
    assign mem_addr  = issue_addr;
    assign mem_write = 1'b0;
    assign mem_wdata = 32'h0;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    knn_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (mem_rdata[7:0]),
        .pop       (pop),
        .flush     (kill),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full_unused),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            issue_addr <= '0;
            issue_left <= '0;
            out_left   <= '0;
            inflight   <= 1'b0;
            drop       <= 1'b0;
        end else if (kill) begin
            state      <= IDLE;
            issue_left <= '0;
            out_left   <= '0;
            inflight   <= 1'b0;
            drop       <= 1'b1;
        end else begin
            drop     <= 1'b0;
            inflight <= mem_valid;
            case (state)
                IDLE: begin
                    if (cmd_valid && !abort) begin
                        issue_addr <= cmd_addr & ~32'd3;
                        issue_left <= cmd_len;
                        out_left   <= cmd_len;
                        if (cmd_len != '0)
                            state <= STREAM;
                    end
                end
                STREAM: begin
                    if (mem_valid) begin
                        issue_addr <= issue_addr + KNN_WORD_STRIDE;
                        issue_left <= issue_left - 1'b1;
                        if (issue_left == LEN_W'(1))
                            state <= DRAIN;
                    end
                    if (pop)
                        out_left <= out_left - 1'b1;
                end
                DRAIN: begin
                    if (pop) begin
                        out_left <= out_left - 1'b1;
                        if (out_left == LEN_W'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_byte_streamer.sv
// Scoreboard bench for knn_byte_streamer: expected bytes/addresses queued at command time,
// a forked monitor compares every mem request and output handshake.
module tb_knn_byte_streamer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = 32'h0;
    logic [11:0] cmd_len = 12'h0;
    logic        abort = 1'b0;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        mem_valid;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_hs    = 0;
    int          n_last  = 0;
    int          n_mv    = 0;
    logic [31:0] last_maddr = 32'h0;
    logic [8:0]  exp_q  [$];
    logic [31:0] addr_q [$];

    always #5 clk = ~clk;

    knn_byte_streamer #(.FIFO_DEPTH(4), .LEN_W(12)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .mem_valid (mem_valid),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    // Memory: word k above 0x10000 holds 0xA5A5A500+k, answered one cycle later.
    always @(posedge clk) begin
        mem_ready <= mem_valid;
        mem_rdata <= 32'hA5A5_A500 + ((mem_addr - 32'h0001_0000) >> 2);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic monitor();
        logic [31:0] ea;
        logic [8:0]  eb;
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                n_mv++;
                last_maddr = mem_addr;
                if (addr_q.size() == 0) fail("mem_addr unexpected request");
                else begin
                    ea = addr_q.pop_front();
                    check("mem_addr", mem_addr, ea);
                end
            end
            if (out_valid && out_ready) begin
                n_hs++;
                if (out_last) n_last++;
                if (exp_q.size() == 0) fail("out unexpected byte");
                else begin
                    eb = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(eb[7:0]));
                    check("out_last", 32'(out_last), 32'(eb[8]));
                end
            end
        end
    endtask

    // Called #1 after a posedge; returns #1 after the handshake edge.
    task automatic send_cmd(input logic [31:0] a, input logic [11:0] len);
        logic [31:0] w;
        logic [31:0] k;
        for (int i = 0; i < int'(len); i++) begin
            w = (a & ~32'd3) + 32'(4 * i);
            k = (w - 32'h0001_0000) >> 2;
            addr_q.push_back(w);
            exp_q.push_back({(i == int'(len) - 1), k[7:0]});
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) fail({name, " timeout"});
        @(posedge clk);
        #1;
        check({name, " all bytes seen"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({name, " busy"},      32'(busy),      32'd0);
        check({name, " out_valid"}, 32'(out_valid), 32'd0);
        check({name, " out_last"},  32'(out_last),  32'd0);
        check({name, " out_data"},  32'(out_data),  32'd0);
        check({name, " mem_valid"}, 32'(mem_valid), 32'd0);
        check({name, " mem_addr"},  mem_addr,       32'd0);
    endtask

    task automatic run_basic(input string name);
        int first_v = -1;
        int idle_c  = -1;
        logic cr = 1'b0;
        out_ready = 1'b1;
        send_cmd(32'h0001_0000, 12'd5);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (out_valid && first_v < 0) first_v = k;
            if (!busy && idle_c < 0) begin
                idle_c = k;
                cr = cmd_ready;
            end
        end
        @(posedge clk);
        #1;
        check({name, " first byte cycle"}, 32'(first_v), 32'd3);
        check({name, " idle cycle"},       32'(idle_c),  32'd8);
        check({name, " cmd_ready at idle"}, 32'(cr),     32'd1);
        check({name, " all bytes seen"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int b_hs, b_last, b_mv, max_out, outst;
        logic seen;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        check("reset mem_write", 32'(mem_write), 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_basic("basic");

        // Full record length
        b_hs = n_hs; b_last = n_last; b_mv = n_mv;
        out_ready = 1'b1;
        send_cmd(32'h0001_0000, 12'd3073);
        wait_done("record", 5000);
        check("record handshakes", 32'(n_hs - b_hs),     32'd3073);
        check("record out_last",   32'(n_last - b_last), 32'd1);
        check("record mem_valid",  32'(n_mv - b_mv),     32'd3073);
        check("record final addr", last_maddr,           32'h0001_3000);

        // Random backpressure at 30% ready
        b_hs = n_hs; b_mv = n_mv; max_out = 0;
        out_ready = ($urandom_range(0, 99) < 30);
        send_cmd(32'h0001_0040, 12'd40);
        for (int k = 0; k < 2000 && (busy || exp_q.size() != 0); k++) begin
            out_ready = ($urandom_range(0, 99) < 30);
            outst = (n_mv - b_mv) - (n_hs - b_hs);
            if (outst > max_out) max_out = outst;
            @(posedge clk);
            #1;
        end
        check("bp all bytes seen", 32'(exp_q.size()), 32'd0);
        check("bp handshakes", 32'(n_hs - b_hs), 32'd40);
        check("bp outstanding within depth", 32'(max_out <= 4), 32'd1);
        check("bp credit reaches depth", 32'(max_out), 32'd4);

        // Zero length
        b_mv = n_mv; seen = 1'b0;
        out_ready = 1'b1;
        send_cmd(32'h0001_0000, 12'd0);
        repeat (5) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        check("zero len busy", 32'(seen), 32'd0);
        check("zero len mem_valid", 32'(n_mv - b_mv), 32'd0);
        check("zero len cmd_ready", 32'(cmd_ready), 32'd1);

        // Unaligned address
        send_cmd(32'h0001_0003, 12'd2);
        wait_done("unaligned", 50);

        // Abort on the 3rd output byte
        b_hs = n_hs;
        out_ready = 1'b1;
        send_cmd(32'h0001_0000, 12'd10);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("abort 3rd byte valid", 32'(out_valid), 32'd1);
        check("abort 3rd byte data",  32'(out_data),  32'h02);
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        addr_q.delete();
        check("abort bytes before", 32'(n_hs - b_hs), 32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("abort out_valid next", 32'(out_valid), 32'd0);
        check("abort busy next", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort in-flight dropped", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        send_cmd(32'h0001_0020, 12'd2);
        wait_done("after abort", 50);

        // Reset mid-burst
        out_ready = 1'b1;
        send_cmd(32'h0001_0000, 12'd5);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        check_reset_values("midreset");
        @(posedge clk);
        #1;
        run_basic("post reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
